// File: rtl/swc_pck_transfer_fanout_if.sv
// Descriptor transfer bus between input blocks, the fan-out arbiter and output blocks.
// Input-block side drives requests and output pops; the arbiter drives acks and FIFO heads.
interface swc_pck_transfer_fanout_if #(
  parameter int unsigned g_num_ports       = 11,
  parameter int unsigned g_page_addr_width = 10,
  parameter int unsigned g_prio_width      = 3
);
  localparam int unsigned N = g_num_ports;
  localparam int unsigned A = g_page_addr_width;
  localparam int unsigned P = g_prio_width;

  logic [N-1:0]   ib_transfer_pck_i;
  logic [N-1:0]   ib_transfer_ack_o;
  logic [N-1:0]   ib_busy_o;
  logic [N*A-1:0] ib_pageaddr_i;
  logic [N*N-1:0] ib_mask_i;
  logic [N*P-1:0] ib_prio_i;
  logic [N-1:0]   ob_data_valid_o;
  logic [N-1:0]   ob_ack_i;
  logic [N*A-1:0] ob_pageaddr_o;
  logic [N*P-1:0] ob_prio_o;

  modport master (
    output ib_transfer_pck_i, ib_pageaddr_i, ib_mask_i, ib_prio_i, ob_ack_i,
    input  ib_transfer_ack_o, ib_busy_o, ob_data_valid_o, ob_pageaddr_o, ob_prio_o
  );

  modport slave (
    input  ib_transfer_pck_i, ib_pageaddr_i, ib_mask_i, ib_prio_i, ob_ack_i,
    output ib_transfer_ack_o, ib_busy_o, ob_data_valid_o, ob_pageaddr_o, ob_prio_o
  );
endinterface

// File: rtl/swc_pck_transfer_fanout.sv
// Multicast page-descriptor fan-out: per-input slots with pending masks, and per-output
// round-robin arbiters feeding small descriptor FIFOs.
module swc_pck_transfer_fanout #(
  parameter int unsigned g_num_ports       = 11,
  parameter int unsigned g_page_addr_width = 10,
  parameter int unsigned g_prio_width      = 3,
  parameter int unsigned g_ob_fifo_depth   = 4
) (
  input logic                      clk_i,
  input logic                      rst_n_i,
  swc_pck_transfer_fanout_if.slave bus
);
  localparam int unsigned N     = g_num_ports;
  localparam int unsigned A     = g_page_addr_width;
  localparam int unsigned P     = g_prio_width;
  localparam int unsigned D     = g_ob_fifo_depth;
  localparam int unsigned PTR_W = $clog2(D);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned RR_W  = (N > 1) ? $clog2(N) : 1;

  typedef struct packed {
    logic [A-1:0] addr;
    logic [P-1:0] prio;
  } entry_t;

  logic [N-1:0]     busy_q;
  logic [N-1:0]     ack_q;
  logic [A-1:0]     addr_q   [N];
  logic [P-1:0]     prio_q   [N];
  logic [N-1:0]     pend_q   [N];
  entry_t           mem_q    [N][D];
  logic [PTR_W-1:0] wr_ptr_q [N];
  logic [PTR_W-1:0] rd_ptr_q [N];
  logic [CNT_W-1:0] cnt_q    [N];
  logic [RR_W-1:0]  rr_q     [N];

  logic [N-1:0]     gnt_vld_c;
  logic [RR_W-1:0]  gnt_idx_c  [N];
  logic [N-1:0]     pend_nxt_c [N];
  logic [N-1:0]     pop_c;
  logic [N-1:0]     valid_c;
  logic [N*A-1:0]   addr_c;
  logic [N*P-1:0]   prio_c;

  // Per-output round-robin grant (only when not full), then strip granted bits from slots.
  always_comb begin : arbitrate
    int idx;
    idx = 0;
    for (int j = 0; j < N; j++) begin
      gnt_vld_c[j] = 1'b0;
      gnt_idx_c[j] = '0;
      pop_c[j]     = bus.ob_ack_i[j] && (cnt_q[j] != '0);
      if (cnt_q[j] != CNT_W'(D)) begin
        for (int k = 0; k < N; k++) begin
          idx = (int'(rr_q[j]) + k) % int'(N);
          if (!gnt_vld_c[j] && pend_q[idx][j]) begin
            gnt_vld_c[j] = 1'b1;
            gnt_idx_c[j] = RR_W'(idx);
          end
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      pend_nxt_c[i] = pend_q[i];
      for (int j = 0; j < N; j++) begin
        if (gnt_vld_c[j] && (int'(gnt_idx_c[j]) == i)) pend_nxt_c[i][j] = 1'b0;
      end
    end
  end

  // Slot capture/completion and FIFO/RR pointer bookkeeping.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      busy_q <= '0;
      ack_q  <= '0;
      for (int i = 0; i < N; i++) begin
        addr_q[i]   <= '0;
        prio_q[i]   <= '0;
        pend_q[i]   <= '0;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
        rr_q[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        ack_q[i] <= 1'b0;
        if (busy_q[i]) begin
          pend_q[i] <= pend_nxt_c[i];
          if (pend_nxt_c[i] == '0) begin
            busy_q[i] <= 1'b0;
            ack_q[i]  <= 1'b1;
          end
        end else if (bus.ib_transfer_pck_i[i]) begin
          addr_q[i] <= bus.ib_pageaddr_i[A*i +: A];
          prio_q[i] <= bus.ib_prio_i[P*i +: P];
          pend_q[i] <= bus.ib_mask_i[N*i +: N];
          if (bus.ib_mask_i[N*i +: N] == '0) ack_q[i]  <= 1'b1;
          else                                busy_q[i] <= 1'b1;
        end
      end
      for (int j = 0; j < N; j++) begin
        if (gnt_vld_c[j]) begin
          wr_ptr_q[j] <= wr_ptr_q[j] + PTR_W'(1);
          rr_q[j]     <= RR_W'((int'(gnt_idx_c[j]) + 1) % int'(N));
        end
        if (pop_c[j]) rd_ptr_q[j] <= rd_ptr_q[j] + PTR_W'(1);
        cnt_q[j] <= cnt_q[j] + CNT_W'(gnt_vld_c[j]) - CNT_W'(pop_c[j]);
      end
    end
  end

  // Descriptor storage needs no reset: heads are masked by the valid count.
  always_ff @(posedge clk_i) begin
    for (int j = 0; j < N; j++) begin
      if (gnt_vld_c[j]) mem_q[j][wr_ptr_q[j]] <= {addr_q[gnt_idx_c[j]], prio_q[gnt_idx_c[j]]};
    end
  end

  always_comb begin : heads
    entry_t head;
    head    = '0;
    valid_c = '0;
    addr_c  = '0;
    prio_c  = '0;
    for (int j = 0; j < N; j++) begin
      valid_c[j] = (cnt_q[j] != '0);
      head       = mem_q[j][rd_ptr_q[j]];
      if (valid_c[j]) begin
        addr_c[A*j +: A] = head.addr;
        prio_c[P*j +: P] = head.prio;
      end
    end
  end

  assign bus.ib_transfer_ack_o = ack_q;
  assign bus.ib_busy_o         = busy_q;
  assign bus.ob_data_valid_o   = valid_c;
  assign bus.ob_pageaddr_o     = addr_c;
  assign bus.ob_prio_o         = prio_c;
endmodule
